load_store_unit: RTL and testbench

//   Data-side memory for the single-cycle/multi-cycle RISC-V core: accepts load/store

---
 rtl/lsu_pkg.sv | 48 ++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/load_store_unit.sv | 149 ++++++++++++++
 tb/tb_load_store_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants, request payload type and decode helpers for the load/store unit.
package lsu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned LANES  = XLEN / BYTE_W;

    // RV32I load/store width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // FSM encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic            we;
        logic [2:0]      funct3;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } lsu_req_t;

    // Stores only support the signed width codes; loads add the unsigned ones.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return ok;
    endfunction

    // Halves need even addresses, words need 4-byte alignment.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic mis;
        case (f3[1:0])
            2'b01:   mis = off[0];
            2'b10:   mis = (off != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Picks the addressed byte/half out of a RAM word and sign/zero-extends it.
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [XLEN-1:0] i_word,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_data_c
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane select followed by width/sign extension
    always_comb begin
        case (i_off)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half   = i_off[1] ? i_word[31:16] : i_word[15:0];
        o_data_c = '0;
        case (i_funct3)
            F3_B:    o_data_c = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data_c = {{16{w_half[15]}}, w_half};
            F3_W:    o_data_c = i_word;
            F3_BU:   o_data_c = {24'd0, w_byte};
            F3_HU:   o_data_c = {16'd0, w_half};
            default: o_data_c = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Fixed-latency data memory: one outstanding request, single-cycle response pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err
);

    localparam int unsigned AW    = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    lsu_req_t         r_req;
    logic             r_ready;
    logic             r_resp_valid;
    logic             r_resp_err;
    logic [XLEN-1:0]  r_resp_rdata;

    logic [LANES-1:0][BYTE_W-1:0] r_mem [DEPTH_WORDS];

    logic             w_accept;
    logic             w_commit;
    logic             w_err;
    logic [AW-1:0]    w_idx;
    logic [1:0]       w_off;
    logic [LANES-1:0] w_be;
    logic [XLEN-1:0]  w_wdata_rep;
    logic [XLEN-1:0]  w_load_c;
    logic             w_unused;

    assign w_idx    = r_req.addr[AW+1:2];
    assign w_off    = r_req.addr[1:0];
    assign w_err    = !f3_legal(r_req.we, r_req.funct3) || misaligned(r_req.funct3, w_off);
    // Address bits above the RAM index wrap and are deliberately dropped.
    assign w_unused = ^r_req.addr[XLEN-1:AW+2];

    // Next-state decode; accept only from IDLE, commit when the countdown expires
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Capture, countdown, handshake and response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt        <= '0;
            r_req        <= '0;
            r_ready      <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_ready      <= (w_state_nxt == ST_IDLE);
            r_resp_valid <= w_commit;
            if (w_accept) begin
                r_req <= '{we: req_we, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
                r_cnt <= CNT_W'(LATENCY - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_commit) begin
                r_resp_err   <= w_err;
                r_resp_rdata <= (w_err || r_req.we) ? '0 : w_load_c;
            end
        end
    end

    // Store lane enables and data replicated across the lanes they may hit
    always_comb begin
        case (r_req.funct3[1:0])
            2'b00: begin
                w_be        = LANES'(1) << w_off;
                w_wdata_rep = {4{r_req.wdata[7:0]}};
            end
            2'b01: begin
                w_be        = w_off[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep = {2{r_req.wdata[15:0]}};
            end
            default: begin
                w_be        = 4'b1111;
                w_wdata_rep = r_req.wdata;
            end
        endcase
    end

    // Byte-lane RAM write at the commit edge; contents are not reset
    always_ff @(posedge clk) begin
        if (w_commit && r_req.we && !w_err) begin
            for (int i = 0; i < LANES; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i] <= w_wdata_rep[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    lsu_load_align u_align (
        .i_word   (r_mem[w_idx]),
        .i_off    (w_off),
        .i_funct3 (r_req.funct3),
        .o_data_c (w_load_c)
    );

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit against a byte-addressed reference model.
module tb_load_store_unit;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] model [DEPTH];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    // Reference: legality, alignment and byte-level memory semantics of RV32I accesses
    task automatic model_apply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int unsigned sz, idx, off;
        logic legal;
        logic [31:0] v;
        sz  = 1 << f3[1:0];
        idx = (addr / 4) % DEPTH;
        off = addr % 4;
        if (we) legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        er = !legal || (addr % sz != 0);
        rd = 32'd0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < int'(sz); i++) model[idx][(off + i) * 8 +: 8] = wdata[i * 8 +: 8];
            end else begin
                v = model[idx] >> (off * 8);
                if (sz == 1)      rd = f3[2] ? (v & 32'hFF)   : {{24{v[7]}}, v[7:0]};
                else if (sz == 2) rd = f3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
                else              rd = v;
            end
        end
    endtask

    // One full transaction with latency, handshake and response-hold checks
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input string tag, output logic [31:0] rd_out);
        logic [31:0] exp_rd, held;
        logic exp_er;
        int k;
        bit got;
        rd_out = 32'd0;
        k = 0;
        @(negedge clk);
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        n_checks++;
        if (!req_ready) begin
            n_errors++;
            $display("FAIL %s ready_timeout: req_ready=%b required 1", tag, req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        @(posedge clk); #1;
        req_valid = 1'b0;
        model_apply(we, f3, addr, wdata, exp_rd, exp_er);
        got = 0;
        for (k = 1; k <= int'(LAT) + 4; k++) begin
            if (k > 1) begin @(posedge clk); #1; end
            else       begin @(posedge clk); #1; end
            if (resp_valid) begin got = 1; break; end
        end
        n_checks++;
        if (!got || k != int'(LAT)) begin
            n_errors++;
            $display("FAIL %s latency: got=%0d cycles (seen=%0d) required %0d", tag, k, got, LAT);
        end
        if (!got) return;
        n_checks++;
        if (resp_rdata !== exp_rd || resp_err !== exp_er) begin
            n_errors++;
            $display("FAIL %s resp: rdata=%h err=%b required rdata=%h err=%b",
                     tag, resp_rdata, resp_err, exp_rd, exp_er);
        end
        n_checks++;
        if (req_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL %s ready_during_resp: %b required 0", tag, req_ready);
        end
        rd_out = resp_rdata;
        held = resp_rdata;
        @(posedge clk); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || resp_rdata !== held) begin
            n_errors++;
            $display("FAIL %s after_resp: valid=%b ready=%b rdata=%h required 0 1 %h",
                     tag, resp_valid, req_ready, resp_rdata, held);
        end
    endtask

    task automatic test_reset();
        req_valid = 1'b1; req_we = 1'b1; req_addr = $urandom; req_wdata = $urandom;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_state: ready=%b valid=%b rdata=%h err=%b required 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_fill();
        logic [31:0] rd;
        for (int i = 0; i < int'(DEPTH); i++) do_req(1'b1, 3'b010, 32'(i * 4), $urandom, "fill", rd);
    endtask

    task automatic test_spec_vectors();
        logic [31:0] rd;
        do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, "sw_10", rd);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_10", rd);
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL lw_const: %h required deadbeef", rd); end
        do_req(1'b1, 3'b000, 32'h13, 32'h80, "sb_13", rd);
        do_req(1'b0, 3'b000, 32'h13, 32'h0, "lb_13", rd);
        n_checks++;
        if (rd !== 32'hFFFFFF80) begin n_errors++; $display("FAIL lb_const: %h required ffffff80", rd); end
        do_req(1'b0, 3'b100, 32'h13, 32'h0, "lbu_13", rd);
        n_checks++;
        if (rd !== 32'h00000080) begin n_errors++; $display("FAIL lbu_const: %h required 00000080", rd); end
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_after_sb", rd);
        n_checks++;
        if (rd !== 32'h80ADBEEF) begin n_errors++; $display("FAIL sb_merge: %h required 80adbeef", rd); end
        do_req(1'b0, 3'b001, 32'h11, 32'h0, "lh_mis", rd);
        do_req(1'b1, 3'b010, 32'h12, 32'h11111111, "sw_mis", rd);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, "ld_f3_011", rd);
        do_req(1'b1, 3'b100, 32'h10, 32'h22222222, "st_f3_100", rd);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, "lw_unchanged", rd);
        n_checks++;
        if (rd !== 32'h80ADBEEF) begin n_errors++; $display("FAIL err_no_write: %h required 80adbeef", rd); end
        do_req(1'b1, 3'b010, 32'(DEPTH * 4 + 8), 32'hCAFEF00D, "sw_wrap", rd);
        do_req(1'b0, 3'b010, 32'h8, 32'h0, "lw_wrap", rd);
        n_checks++;
        if (rd !== 32'hCAFEF00D) begin n_errors++; $display("FAIL wrap: %h required cafef00d", rd); end
    endtask

    task automatic test_reset_mid_wait();
        logic [31:0] prior, rd;
        bit seen;
        prior = model[8];
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h12345678;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_wait_reset: ready=%b valid=%b required 1 0", req_ready, resp_valid);
        end
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        repeat (6) begin @(posedge clk); #1; if (resp_valid) seen = 1; end
        n_checks++;
        if (seen) begin n_errors++; $display("FAIL abandoned_resp: resp_valid seen=1 required 0"); end
        do_req(1'b0, 3'b010, 32'h20, 32'h0, "lw_after_abort", rd);
        n_checks++;
        if (rd !== prior) begin n_errors++; $display("FAIL abort_no_write: %h required %h", rd, prior); end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] exp_rd, rd;
        logic exp_er;
        bit got;
        model_apply(1'b0, 3'b010, 32'h10, 32'h0, exp_rd, exp_er);
        @(negedge clk);
        while (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_we = 1'b1; req_addr = 32'h30; req_wdata = ~model[12];
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            @(posedge clk); #1;
            if (resp_valid) got = 1;
        end
        req_valid = 1'b0;
        n_checks++;
        if (!got || resp_rdata !== exp_rd || resp_err !== exp_er) begin
            n_errors++;
            $display("FAIL busy_resp: seen=%b rdata=%h err=%b required 1 %h %b",
                     got, resp_rdata, resp_err, exp_rd, exp_er);
        end
        do_req(1'b0, 3'b010, 32'h30, 32'h0, "busy_ignored", rd);
    endtask

    task automatic test_random();
        logic [31:0] rd, a;
        logic [2:0] f3;
        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = {$urandom_range(0, 7) == 0 ? 22'($urandom) : 22'd0, 10'($urandom)};
            do_req(1'($urandom), f3, a, $urandom, "random", rd);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_spec_vectors();
        test_reset_mid_wait();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
